// File: rtl/parking_exit_sequencer_if.sv
// Exit-request channel of the parking exit sequencer: valid/ready request
// plus the one-cycle error pulse returned when the requested slot was empty.
interface parking_exit_sequencer_if;
    logic       exit_valid;
    logic [2:0] exit_slot;
    logic       exit_ready;
    logic       exit_error;

    modport master (
        output exit_valid,
        output exit_slot,
        input  exit_ready,
        input  exit_error
    );

    modport slave (
        input  exit_valid,
        input  exit_slot,
        output exit_ready,
        output exit_error
    );
endinterface

// File: rtl/parking_exit_sequencer.sv
// Parking lot entry allocator and exit sequencer feeding the exit-location decoder.
// Optional feature macro: STATS_COUNTERS_EN adds saturating exit/error counters.
module parking_exit_sequencer #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enter_req,
    output logic                            entry_ack,
    output logic [2:0]                      entry_slot,
    output logic                            entry_reject,
    parking_exit_sequencer_if.slave         exit_if,
    output logic [2:0]                      park_number,
    output logic                            park_number_valid,
    output logic                            gate_open,
    output logic [7:0]                      occupancy,
    output logic [3:0]                      free_count,
`ifdef STATS_COUNTERS_EN
    output logic [7:0]                      exit_count,
    output logic [7:0]                      error_count,
`endif
    output logic                            lot_full
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CHECK   = 2'd1;
    localparam logic [1:0] OPEN    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [7:0] TIMER_LOAD = 8'(GATE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] occ_q, occ_d;
    logic [3:0] free_q, free_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] park_q, park_d;
    logic       pv_q, pv_d;
    logic       err_q, err_d;
    logic       ack_q, ack_d;
    logic       rej_q, rej_d;
    logic [2:0] entrySlot_q, entrySlot_d;
    logic [2:0] freeIdx;
    logic       grant;
    logic       releasing;

    // Lowest free slot; scanning downward lets the lowest index win.
    always_comb begin
        freeIdx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ_q[i]) freeIdx = 3'(i);
        end
    end

    assign grant     = enter_req && (occ_q != 8'hFF);
    assign releasing = (state_q == RELEASE);

    // Entry uses pre-release occupancy, so the slot being freed is never granted this edge.
    always_comb begin
        occ_d = occ_q;
        if (grant)     occ_d[freeIdx] = 1'b1;
        if (releasing) occ_d[slot_q]  = 1'b0;
        free_d      = free_q + {3'b000, releasing} - {3'b000, grant};
        ack_d       = grant;
        rej_d       = enter_req && (occ_q == 8'hFF);
        entrySlot_d = grant ? freeIdx : entrySlot_q;
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        timer_d = timer_q;
        park_d  = park_q;
        pv_d    = pv_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_if.exit_valid) begin
                    slot_d  = exit_if.exit_slot;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (occ_q[slot_q]) begin
                    state_d = OPEN;
                    park_d  = slot_q;
                    pv_d    = 1'b1;
                    timer_d = TIMER_LOAD;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OPEN: begin
                // Gate drops on the edge leaving OPEN so it is high exactly GATE_CYCLES cycles.
                if (timer_q == 8'd0) begin
                    state_d = RELEASE;
                    pv_d    = 1'b0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            occ_q       <= 8'h00;
            free_q      <= 4'd8;
            slot_q      <= 3'd0;
            timer_q     <= 8'd0;
            park_q      <= 3'd0;
            pv_q        <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
            entrySlot_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
            park_q      <= park_d;
            pv_q        <= pv_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
            entrySlot_q <= entrySlot_d;
        end
    end

`ifdef STATS_COUNTERS_EN
    logic [7:0] exitCount_q;
    logic [7:0] errorCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exitCount_q  <= 8'd0;
            errorCount_q <= 8'd0;
        end else begin
            if (releasing && exitCount_q != 8'hFF) exitCount_q  <= exitCount_q + 8'd1;
            if (err_d && errorCount_q != 8'hFF)    errorCount_q <= errorCount_q + 8'd1;
        end
    end

    assign exit_count  = exitCount_q;
    assign error_count = errorCount_q;
`endif

    assign entry_ack          = ack_q;
    assign entry_slot         = entrySlot_q;
    assign entry_reject       = rej_q;
    assign exit_if.exit_ready = (state_q == IDLE);
    assign exit_if.exit_error = err_q;
    assign park_number        = park_q;
    assign park_number_valid  = pv_q;
    assign gate_open          = pv_q;
    assign occupancy          = occ_q;
    assign free_count         = free_q;
    assign lot_full           = (free_q == 4'd0);

endmodule

// File: tb/tb_parking_exit_sequencer.sv
// Self-checking bench for parking_exit_sequencer: directed scenarios plus
// randomized traffic compared every cycle against a timeline-based model.
module tb_parking_exit_sequencer;

    localparam int G = 4;

    logic       clk;
    logic       rst_n;
    logic       enter_req;
    logic       entry_ack;
    logic [2:0] entry_slot;
    logic       entry_reject;
    logic [2:0] park_number;
    logic       park_number_valid;
    logic       gate_open;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       lot_full;
`ifdef STATS_COUNTERS_EN
    logic [7:0] exit_count;
    logic [7:0] error_count;
`endif

    int checks = 0;
    int errors = 0;

    parking_exit_sequencer_if exitBus ();

    parking_exit_sequencer #(.GATE_CYCLES(G)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enter_req         (enter_req),
        .entry_ack         (entry_ack),
        .entry_slot        (entry_slot),
        .entry_reject      (entry_reject),
        .exit_if           (exitBus.slave),
        .park_number       (park_number),
        .park_number_valid (park_number_valid),
        .gate_open         (gate_open),
        .occupancy         (occupancy),
        .free_count        (free_count),
`ifdef STATS_COUNTERS_EN
        .exit_count        (exit_count),
        .error_count       (error_count),
`endif
        .lot_full          (lot_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an exit handshaken in cycle t checks occupancy in cycle t+1,
    // then either errors in t+2 or holds the gate for t+2..t+G+1 and frees the slot at the end of t+G+2.
    bit [7:0] mOcc;
    bit       mAck, mRej, mErr, mPv;
    bit [2:0] mSlot, mPark, mReq;
    bit       mBusy, mOk;
    int       mHs, mCyc;

    function automatic bit [2:0] lowestFree(input bit [7:0] o);
        for (int i = 0; i < 8; i++) if (!o[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic int popCount(input bit [7:0] o);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(o[i]);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit [7:0] lOcc;
        bit       lAck, lRej, lErr, lBusy, lOk;
        bit [2:0] lSlot, lPark, lReq;
        int       lHs, p, nextCyc;
        if (!rst_n) begin
            mOcc <= 8'h00; mAck <= 0; mRej <= 0; mErr <= 0; mPv <= 0;
            mSlot <= 0; mPark <= 0; mReq <= 0; mBusy <= 0; mOk <= 0;
            mHs <= 0; mCyc <= 0;
        end else begin
            lOcc = mOcc; lSlot = mSlot; lPark = mPark; lReq = mReq;
            lBusy = mBusy; lOk = mOk; lHs = mHs;
            lAck = 0; lRej = 0; lErr = 0;
            if (enter_req) begin
                if (mOcc != 8'hFF) begin
                    lAck = 1; lSlot = lowestFree(mOcc); lOcc[lSlot] = 1'b1;
                end else begin
                    lRej = 1;
                end
            end
            if (mBusy) begin
                p = mCyc - mHs;
                if (p == 1) begin
                    lOk = mOcc[mReq];
                    if (!lOk) begin lErr = 1; lBusy = 0; end
                    else lPark = mReq;
                end else if (p == G + 2) begin
                    lOcc[mReq] = 1'b0;
                    lBusy = 0;
                end
            end else if (exitBus.exit_valid) begin
                lBusy = 1; lHs = mCyc; lReq = exitBus.exit_slot; lOk = 0;
            end
            nextCyc = mCyc + 1;
            mPv   <= lBusy && lOk && (nextCyc - lHs) >= 2 && (nextCyc - lHs) <= G + 1;
            mOcc  <= lOcc; mAck <= lAck; mRej <= lRej; mErr <= lErr;
            mSlot <= lSlot; mPark <= lPark; mReq <= lReq;
            mBusy <= lBusy; mOk <= lOk; mHs <= lHs; mCyc <= nextCyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit ev, input bit [2:0] s);
        enter_req          = e;
        exitBus.exit_valid = ev;
        exitBus.exit_slot  = s;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("entry_ack", 32'(entry_ack), 32'(mAck));
            checkOutput("entry_reject", 32'(entry_reject), 32'(mRej));
            checkOutput("entry_slot", 32'(entry_slot), 32'(mSlot));
            checkOutput("exit_ready", 32'(exitBus.exit_ready), 32'(!mBusy));
            checkOutput("exit_error", 32'(exitBus.exit_error), 32'(mErr));
            checkOutput("park_number_valid", 32'(park_number_valid), 32'(mPv));
            checkOutput("gate_open", 32'(gate_open), 32'(mPv));
            checkOutput("park_number", 32'(park_number), 32'(mPark));
            checkOutput("occupancy", 32'(occupancy), 32'(mOcc));
            checkOutput("free_count", 32'(free_count), 32'(8 - popCount(mOcc)));
            checkOutput("lot_full", 32'(lot_full), 32'(mOcc == 8'hFF));
        end
    end

    initial begin
        rst_n = 1'b0;
        enter_req = 1'b0;
        exitBus.exit_valid = 1'b0;
        exitBus.exit_slot = 3'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset occupancy", 32'(occupancy), 32'h00);
        checkOutput("reset free_count", 32'(free_count), 32'd8);
        checkOutput("reset exit_ready", 32'(exitBus.exit_ready), 32'd1);

        // Three consecutive entries take slots 0,1,2.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput("entry ack", 32'(entry_ack), 32'd1);
            checkOutput("entry slot", 32'(entry_slot), 32'(k));
        end
        checkOutput("three entries occupancy", 32'(occupancy), 32'h07);
        checkOutput("three entries free", 32'(free_count), 32'd5);
        applyStimulus(0, 0, 0);
        checkOutput("entry_slot hold", 32'(entry_slot), 32'd2);

        // Fill the lot and overflow it.
        repeat (5) applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("full reject", 32'(entry_reject), 32'd1);
        checkOutput("full lot_full", 32'(lot_full), 32'd1);
        checkOutput("full occupancy", 32'(occupancy), 32'hFF);

        // Exit of slot 5: gate in T+2..T+5, slot free and ready again at T+7.
        applyStimulus(0, 1, 5);
        checkOutput("exit5 ready T+1", 32'(exitBus.exit_ready), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            applyStimulus(0, 0, 0);
            checkOutput("exit5 gate", 32'(gate_open), 32'(k >= 2 && k <= 5));
            checkOutput("exit5 ready", 32'(exitBus.exit_ready), 32'(k == 7));
            checkOutput("exit5 occ bit", 32'(occupancy[5]), 32'(k < 7));
            if (k == 2) checkOutput("exit5 park_number", 32'(park_number), 32'd5);
        end

        // Exit of the now-empty slot 5 errors at T+2.
        applyStimulus(0, 1, 5);
        applyStimulus(0, 0, 0);
        checkOutput("empty exit error", 32'(exitBus.exit_error), 32'd1);
        checkOutput("empty exit ready", 32'(exitBus.exit_ready), 32'd1);
        checkOutput("empty exit gate", 32'(gate_open), 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("error pulse width", 32'(exitBus.exit_error), 32'd0);

        // Refill, then a release of slot 3 coinciding with an entry.
        applyStimulus(1, 0, 0);
        checkOutput("refill slot", 32'(entry_slot), 32'd5);
        applyStimulus(0, 1, 3);
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("pre-release free", 32'(free_count), 32'd0);
        applyStimulus(1, 0, 0);
        checkOutput("release+entry reject", 32'(entry_reject), 32'd1);
        checkOutput("release+entry free", 32'(free_count), 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("regrant ack", 32'(entry_ack), 32'd1);
        checkOutput("regrant slot", 32'(entry_slot), 32'd3);
        checkOutput("regrant free", 32'(free_count), 32'd0);

        // Asynchronous reset in the middle of OPEN.
        applyStimulus(0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("open gate", 32'(gate_open), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async gate drop", 32'(gate_open), 32'd0);
        checkOutput("async valid drop", 32'(park_number_valid), 32'd0);
        checkOutput("async occupancy", 32'(occupancy), 32'h00);
        checkOutput("async free", 32'(free_count), 32'd8);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic against the model.
        repeat (1500) begin
            applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 50,
                          3'($urandom_range(0, 7)));
        end
        applyStimulus(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
